// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared single-port data/instruction memory. It serialises instruction
// fetches and loads/stores, flags bad word addresses and returns registered data with an ack pulse.
module mem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned MAX_WAIT  = 3
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,

  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,

  output logic        busy
);

  localparam int unsigned WaitW    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [31:0] LastWord = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e           state_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic             sel_d_q;
  logic             we_q;
  logic             err_q;

  logic             grant_i;
  logic             grant_d;
  logic [31:0]      g_addr;
  logic             g_we;
  logic [31:0]      g_wdata;
  logic             g_err;

  // D normally wins a conflict; I is forced through once it has lost MAX_WAIT in a row.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_req && d_req) begin
      if (wait_cnt_q == WaitW'(MAX_WAIT)) begin
        grant_i = 1'b1;
      end else begin
        grant_d = 1'b1;
      end
    end else begin
      grant_i = i_req;
      grant_d = d_req;
    end
    g_addr  = grant_d ? d_addr : i_addr;
    g_we    = grant_d & d_we;
    g_wdata = grant_d ? d_wdata : 32'h0;
    g_err   = (g_addr[1:0] != 2'b00) || (g_addr > LastWord);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      sel_d_q    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      i_ack      <= 1'b0;
      i_err      <= 1'b0;
      i_rdata    <= 32'h0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= 32'h0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wd     <= 32'h0;
      busy       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_i || grant_d) begin
            sel_d_q  <= grant_d;
            we_q     <= g_we;
            err_q    <= g_err;
            mem_addr <= g_addr;
            mem_wd   <= g_wdata;
            MemRead  <= !g_we && !g_err;
            MemWrite <= g_we && !g_err;
            busy     <= 1'b1;
            state_q  <= StAccess;
            if (grant_i) begin
              wait_cnt_q <= '0;
            end else if (i_req && (wait_cnt_q != WaitW'(MAX_WAIT))) begin
              wait_cnt_q <= wait_cnt_q + WaitW'(1);
            end
          end
        end
        StAccess: begin
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          if (sel_d_q) begin
            d_ack   <= 1'b1;
            d_err   <= err_q;
            d_rdata <= (err_q || we_q) ? 32'h0 : mem_rd;
          end else begin
            i_ack   <= 1'b1;
            i_err   <= err_q;
            i_rdata <= (err_q || we_q) ? 32'h0 : mem_rd;
          end
          state_q <= StDone;
        end
        StDone: begin
          i_ack   <= 1'b0;
          i_err   <= 1'b0;
          d_ack   <= 1'b0;
          d_err   <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte memory environment, transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

  localparam int unsigned MemBytes = 1024;
  localparam int unsigned MaxWait  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, i_err, d_ack, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        MemRead, MemWrite, busy;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  always #5 clk = ~clk;

  mem_arbiter #(
    .MEM_BYTES(MemBytes),
    .MAX_WAIT (MaxWait)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_rdata (i_rdata),
    .i_err   (i_err),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .d_err   (d_err),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .mem_addr(mem_addr),
    .mem_wd  (mem_wd),
    .mem_rd  (mem_rd),
    .busy    (busy)
  );

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      16: return 8'h44;
      17: return 8'h33;
      18: return 8'h22;
      19: return 8'h11;
      default: return 8'((i * 7 + 3) % 256);
    endcase
  endfunction

  // Memory environment: little-endian bytes, combinational read, write on posedge.
  logic [7:0] env_mem [MemBytes];

  always_comb begin
    mem_rd = 32'hA5A5_A5A5;
    if (MemRead) begin
      mem_rd = {env_mem[mem_addr[9:0] + 10'd3], env_mem[mem_addr[9:0] + 10'd2],
                env_mem[mem_addr[9:0] + 10'd1], env_mem[mem_addr[9:0]]};
    end
  end

  initial begin
    for (int i = 0; i < MemBytes; i++) env_mem[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (MemWrite === 1'b1) begin
        for (int b = 0; b < 4; b++) begin
          env_mem[(int'(mem_addr[9:0]) + b) % MemBytes] = mem_wd[8*b +: 8];
        end
      end
    end
  end

  function automatic logic [31:0] env_word(input int a);
    return {env_mem[a + 3], env_mem[a + 2], env_mem[a + 1], env_mem[a]};
  endfunction

  // Reference model: one transaction at a time, granted no sooner than 3 edges after the last.
  logic [7:0]  ref_mem [MemBytes];
  int          edge_n, t_g, free_at, wcnt;
  bit          started, act, t_d, t_we, t_err, take_d;
  logic [31:0] t_addr, t_wd, t_rd;
  logic        e_iack, e_ierr, e_dack, e_derr, e_mr, e_mw, e_busy, chk_ma, chk_wd;
  logic [31:0] e_irdata, e_drdata, e_maddr, e_mwd;

  initial begin
    for (int i = 0; i < MemBytes; i++) ref_mem[i] = init_byte(i);
    edge_n = 0; started = 0; act = 0; t_g = 0; free_at = 0; wcnt = 0;
    e_irdata = 0; e_drdata = 0; e_maddr = 0; e_mwd = 0;
    forever begin
      @(posedge clk);
      edge_n++;
      started = 1;
      {e_iack, e_ierr, e_dack, e_derr, e_mr, e_mw, e_busy, chk_ma, chk_wd} = '0;
      if (rst) begin
        act = 0; free_at = edge_n + 1; wcnt = 0;
        e_irdata = 0; e_drdata = 0; e_maddr = 0; e_mwd = 0;
        chk_ma = 1; chk_wd = 1;
      end else begin
        if (act && edge_n == t_g + 1) begin
          e_busy = 1;
          if (t_d) begin e_dack = 1; e_derr = t_err; e_drdata = t_rd; end
          else     begin e_iack = 1; e_ierr = t_err; e_irdata = t_rd; end
        end else if (act && edge_n == t_g + 2) begin
          act = 0;
        end
        if (!act && edge_n >= free_at && (i_req || d_req)) begin
          take_d = d_req && !(i_req && wcnt == MaxWait);
          if (!take_d) wcnt = 0;
          else if (i_req && wcnt < MaxWait) wcnt++;
          t_d    = take_d;
          t_addr = take_d ? d_addr : i_addr;
          t_we   = take_d && d_we;
          t_wd   = d_wdata;
          t_err  = (t_addr % 4 != 0) || (t_addr > 32'(MemBytes - 4));
          t_rd   = 0;
          if (!t_err && t_we) begin
            for (int b = 0; b < 4; b++) ref_mem[t_addr + b] = t_wd[8*b +: 8];
          end else if (!t_err) begin
            for (int b = 0; b < 4; b++) t_rd[8*b +: 8] = ref_mem[t_addr + b];
          end
          act = 1; t_g = edge_n; free_at = edge_n + 3;
          e_busy = 1; e_mr = !t_we && !t_err; e_mw = t_we && !t_err;
          e_maddr = t_addr; chk_ma = 1;
          if (e_mw) begin e_mwd = t_wd; chk_wd = 1; end
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int mr_cnt = 0;
  int mw_cnt = 0;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (edge %0d): got %h, expected %h", name, edge_n, got, exp);
    end
  endtask

  task automatic compare_all();
    if (!started) return;
    cmp("i_ack", 32'(i_ack), 32'(e_iack));
    cmp("i_err", 32'(i_err), 32'(e_ierr));
    cmp("d_ack", 32'(d_ack), 32'(e_dack));
    cmp("d_err", 32'(d_err), 32'(e_derr));
    cmp("busy", 32'(busy), 32'(e_busy));
    cmp("MemRead", 32'(MemRead), 32'(e_mr));
    cmp("MemWrite", 32'(MemWrite), 32'(e_mw));
    cmp("i_rdata", i_rdata, e_irdata);
    cmp("d_rdata", d_rdata, e_drdata);
    if (chk_ma) cmp("mem_addr", mem_addr, e_maddr);
    if (chk_wd) cmp("mem_wd", mem_wd, e_mwd);
    if (MemRead === 1'b1) mr_cnt++;
    if (MemWrite === 1'b1) mw_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  // Idle one cycle, raise one request, wait (bounded) for its ack, then drop it.
  task automatic do_txn(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    tick();
    if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin i_req = 1; i_addr = addr; end
    lat = 0; rdata = 'x; err = 'x;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if ((is_d ? d_ack : i_ack) === 1'b1) begin
        lat = n; rdata = is_d ? d_rdata : i_rdata; err = is_d ? d_err : i_err;
        break;
      end
    end
    i_req = 0; d_req = 0;
    cmp("ack_seen", 32'(lat != 0), 32'd1);
  endtask

  task automatic reset_in_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    int acks;
    tick();
    d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
    tick();
    cmp("busy_in_access", 32'(busy), 32'd1);
    d_req = 0; rst = 1;
    tick();
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_d_ack", 32'(d_ack), 32'd0);
    cmp("rst_MemRead", 32'(MemRead), 32'd0);
    cmp("rst_MemWrite", 32'(MemWrite), 32'd0);
    cmp("rst_d_rdata", d_rdata, 32'd0);
    cmp("rst_mem_addr", mem_addr, 32'd0);
    rst = 0;
    acks = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (d_ack === 1'b1 || i_ack === 1'b1) acks++;
    end
    cmp("no_ack_after_reset", 32'(acks), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return $urandom();
      1: return 32'($urandom_range(0, MemBytes - 1));
      2: return 32'h0000_03FC;
      3: return 32'h0000_0400;
      default: return 32'($urandom_range(0, 15)) * 4;
    endcase
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, mr0, mw0, a1, a2, cnt;
    string       exp_order, got_order;

    rst = 1; i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    tick(); tick();
    cmp("reset_busy", 32'(busy), 32'd0);
    cmp("reset_i_rdata", i_rdata, 32'd0);
    cmp("reset_mem_wd", mem_wd, 32'd0);
    rst = 0;

    mr0 = mr_cnt;
    do_txn(0, 0, 32'h10, 32'h0, rd, er, lat);
    cmp("fetch_rdata", rd, 32'h1122_3344);
    cmp("fetch_err", 32'(er), 32'd0);
    cmp("fetch_latency", 32'(lat), 32'd2);
    cmp("fetch_memread_cycles", 32'(mr_cnt - mr0), 32'd1);

    mw0 = mw_cnt;
    do_txn(1, 1, 32'h20, 32'hDEAD_BEEF, rd, er, lat);
    cmp("store_err", 32'(er), 32'd0);
    cmp("store_memwrite_cycles", 32'(mw_cnt - mw0), 32'd1);
    cmp("store_committed", env_word(32'h20), 32'hDEAD_BEEF);
    do_txn(1, 0, 32'h20, 32'h0, rd, er, lat);
    cmp("load_after_store", rd, 32'hDEAD_BEEF);

    mr0 = mr_cnt; mw0 = mw_cnt;
    do_txn(1, 1, 32'h22, 32'h1234_5678, rd, er, lat);
    cmp("misaligned_store_err", 32'(er), 32'd1);
    cmp("misaligned_store_rdata", rd, 32'd0);
    do_txn(0, 0, 32'h3FD, 32'h0, rd, er, lat);
    cmp("oor_fetch_err", 32'(er), 32'd1);
    cmp("oor_fetch_rdata", rd, 32'd0);
    cmp("err_no_memread", 32'(mr_cnt - mr0), 32'd0);
    cmp("err_no_memwrite", 32'(mw_cnt - mw0), 32'd0);
    cmp("err_mem_0x20", env_word(32'h20), 32'hDEAD_BEEF);
    cmp("err_mem_0x24", env_word(32'h24), 32'h140D_06FF);

    do_txn(0, 0, 32'h3FC, 32'h0, rd, er, lat);
    cmp("last_word_err", 32'(er), 32'd0);
    cmp("last_word_rdata", rd, 32'hFCF5_EEE7);
    do_txn(0, 0, 32'h400, 32'h0, rd, er, lat);
    cmp("past_end_err", 32'(er), 32'd1);
    do_txn(1, 0, 32'h8000_0000, 32'h0, rd, er, lat);
    cmp("high_addr_err", 32'(er), 32'd1);

    // Held fetch request: back-to-back grants.
    tick();
    i_req = 1; i_addr = 32'h10;
    a1 = -1; a2 = -1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (i_ack === 1'b1) begin
        if (a1 < 0) a1 = n;
        else begin a2 = n; break; end
      end
    end
    i_req = 0;
    cmp("held_first_ack", 32'(a1), 32'd2);
    cmp("held_ack_gap", 32'(a2 - a1), 32'd3);

    // Conflict: both ports held after a fresh reset.
    rst = 1; tick(); rst = 0;
    i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h20;
    exp_order = "DDDIDDDI";
    got_order = "--------";
    cnt = 0;
    for (int n = 0; n < 40 && cnt < 8; n++) begin
      tick();
      if (d_ack === 1'b1) begin got_order[cnt] = "D"; cnt++; end
      else if (i_ack === 1'b1) begin got_order[cnt] = "I"; cnt++; end
    end
    i_req = 0; d_req = 0;
    for (int k = 0; k < 8; k++) begin
      cmp($sformatf("grant_order_%0d", k), 32'(got_order[k]), 32'(exp_order[k]));
    end

    tick();
    reset_in_access(0, 32'h10, 32'h0);
    reset_in_access(1, 32'h30, 32'hCAFE_F00D);
    cmp("store_through_reset", env_word(32'h30), 32'hCAFE_F00D);
    do_txn(1, 0, 32'h30, 32'h0, rd, er, lat);
    cmp("load_after_reset_store", rd, 32'hCAFE_F00D);

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 600; n++) begin
      tick();
      rst     = ($urandom_range(0, 60) == 0);
      i_req   = ($urandom_range(0, 2) != 0);
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = $urandom_range(0, 1) == 1;
      d_wdata = $urandom();
      if ($urandom_range(0, 3) == 0) i_addr = rand_addr();
      if ($urandom_range(0, 3) == 0) d_addr = rand_addr();
    end
    rst = 0; i_req = 0; d_req = 0;
    for (int n = 0; n < 5; n++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
